// File: rtl/alu_issue_ctrl.sv
// Issue controller between the instruction FIFO and the 4-bit ALU: pops and decodes
// instructions, sequences multi-cycle ops, and drives the ALU clock-gate enable.
module alu_issue_ctrl #(
    parameter int IDLE_CYCLES = 4,
    parameter int MUL_LAT     = 2,
    parameter int DIV_LAT     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [11:0] fifo_dout,
    output logic        fifo_rd_en,
    input  logic        clock_disable,
    output logic [3:0]  alu_op,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic        alu_start,
    output logic        gate_en,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        illegal,
    output logic        busy,
    output logic [7:0]  issued_cnt
);

    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int EXEC_W  = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam int IDLE_W  = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        SLEEP,
        WAKE,
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        DONE
    } state_t;

    state_t              state;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [EXEC_W-1:0]   exec_cnt;
    logic [EXEC_W-1:0]   exec_last;
    logic                go;

    assign go = !fifo_empty && !clock_disable;

    // Final EXEC cycle index for the opcode held in the operand registers.
    always_comb begin
        exec_last = '0;
        case (alu_op)
            4'd2:    exec_last = EXEC_W'(MUL_LAT - 1);
            4'd3:    exec_last = EXEC_W'(DIV_LAT - 1);
            default: exec_last = '0;
        endcase
    end

    // Outputs are set on entry to each state so every output is a plain flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SLEEP;
            idle_cnt   <= '0;
            exec_cnt   <= '0;
            fifo_rd_en <= 1'b0;
            alu_op     <= 4'd0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_start  <= 1'b0;
            gate_en    <= 1'b0;
            res_valid  <= 1'b0;
            illegal    <= 1'b0;
            busy       <= 1'b0;
            issued_cnt <= 8'd0;
        end else begin
            fifo_rd_en <= 1'b0;
            alu_start  <= 1'b0;
            illegal    <= 1'b0;
            case (state)
                SLEEP: begin
                    if (go) begin
                        state   <= WAKE;
                        gate_en <= 1'b1;
                    end
                end
                WAKE: begin
                    state      <= FETCH;
                    fifo_rd_en <= 1'b1;
                    busy       <= 1'b1;
                end
                IDLE: begin
                    if (go) begin
                        state      <= FETCH;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                        idle_cnt   <= '0;
                    end else if (clock_disable || idle_cnt == IDLE_W'(IDLE_CYCLES - 1)) begin
                        state    <= SLEEP;
                        gate_en  <= 1'b0;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                FETCH: begin
                    state <= DECODE;
                end
                DECODE: begin
                    alu_op <= fifo_dout[11:8];
                    alu_a  <= fifo_dout[7:4];
                    alu_b  <= fifo_dout[3:0];
                    if (fifo_dout[11]) begin
                        state   <= IDLE;
                        illegal <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        state      <= EXEC;
                        alu_start  <= 1'b1;
                        issued_cnt <= issued_cnt + 8'd1;
                        exec_cnt   <= '0;
                    end
                end
                EXEC: begin
                    if (exec_cnt == exec_last) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end else begin
                        exec_cnt <= exec_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (go) begin
                            state      <= FETCH;
                            fifo_rd_en <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= SLEEP;
                    gate_en <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue controller and clock-gating scheduler between the 12-bit instruction FIFO and the 4-bit ALU of the combined FIFO/ALU datapath. Pops instructions from the FIFO and decodes them into opcode/operand registers. Sequences single- and multi-cycle ALU operations and holds each result under a valid/ready handshake. Generates the ALU clock-gate enable from idle detection and the external `clock_disable` request, and never gates the ALU clock while an operation is in flight.

## Interface
- `IDLE_CYCLES`, default 4: consecutive idle cycles in IDLE before gating the ALU clock (≥1).
- `MUL_LAT`, default 2: execute cycles for opcode 2, multiply (≥1).
- `DIV_LAT`, default 4: execute cycles for opcode 3, divide (≥1).
- `clk`  in  1  single clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  instruction FIFO empty flag.
- `fifo_dout`  in  12  FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  one-cycle pop strobe.
- `clock_disable`  in  1  external request to gate the ALU clock.
- `alu_op`  out  4  registered opcode, `instr[11:8]`.
- `alu_a`  out  4  registered operand A, `instr[7:4]`.
- `alu_b`  out  4  registered operand B, `instr[3:0]`.
- `alu_start`  out  1  one-cycle pulse on the first execute cycle.
- `gate_en`  out  1  ALU clock-gate enable, registered and glitch-free.
- `res_valid`  out  1  ALU result ready.
- `res_ready`  in  1  consumer accepts the result.
- `illegal`  out  1  one-cycle pulse when the decoded opcode is >7.
- `busy`  out  1  high in FETCH, DECODE, EXEC, DONE.
- `issued_cnt`  out  8  count of legal instructions issued; wraps 255→0.

## Operation
- States: SLEEP, WAKE, IDLE, FETCH, DECODE, EXEC, DONE.
- `go` = `!fifo_empty && !clock_disable`.
- **SLEEP**: `gate_en`=0.
  - `go` → WAKE; otherwise stay.
- **WAKE**: `gate_en`=1, one cycle for the gated clock to restart.
  - Always → FETCH.
- **IDLE**: `gate_en`=1; the idle counter increments each cycle.
  - `go` → FETCH.
  - Else `clock_disable`=1 → SLEEP.
  - Else idle counter = `IDLE_CYCLES`-1 → SLEEP.
  - The counter clears on any exit from IDLE.
- **FETCH**: `fifo_rd_en`=1.
  - Always → DECODE.
- **DECODE**: capture `fifo_dout` into `alu_op`/`alu_a`/`alu_b`.
  - `fifo_dout[11:8]`>7: pulse `illegal`, leave `issued_cnt` unchanged, → IDLE.
  - Otherwise → EXEC.
- **EXEC**: `alu_start`=1 in the first cycle; `issued_cnt`+1 in the first cycle.
  - Stay L cycles, where L = `MUL_LAT` for op 2, `DIV_LAT` for op 3, and 1 for ops 0,1,4,5,6,7.
  - Then → DONE.
- **DONE**: `res_valid`=1 until `res_ready`=1. On the accept cycle:
  - `go` → FETCH (back-to-back issue).
  - Otherwise → IDLE.
- `clock_disable` is sampled only in SLEEP, IDLE and on DONE exit. In FETCH..DONE it is ignored and `gate_en` stays 1.
- `fifo_empty` is sampled only in SLEEP, IDLE and on DONE exit. The controller never pops when empty, so at most one pop is outstanding.
- Opcode map, informational (the ALU owns the arithmetic): 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 not A.

## Timing
- Reset (`rst`=0, async): state=SLEEP, and every output is 0: `gate_en`, `fifo_rd_en`, `alu_op`, `alu_a`, `alu_b`, `alu_start`, `res_valid`, `illegal`, `busy`, `issued_cnt`. The idle counter is also 0.
- Reset release is synchronous to the first `clk` edge after `rst` rises.
- Reset mid-operation: an in-flight instruction is dropped; the FIFO pop already taken is not restored.
- All outputs are registered; no combinational path from input to output.
- Wake latency, single-cycle op: SLEEP sees `go` at edge 0. WAKE at 1, FETCH at 2, DECODE at 3, EXEC at 4, `res_valid` at 5.
- From IDLE: `res_valid` 3+L cycles after the edge that sees `go`.
- Back-to-back throughput with `res_ready`=1: one instruction per 3+L cycles.
- `res_ready` asserted in the same cycle `res_valid` rises is accepted in that cycle.
- `alu_op`/`alu_a`/`alu_b` hold from DECODE until the next DECODE.
- `gate_en` falls only on entry to SLEEP and rises on entry to WAKE; minimum low time is one cycle.

## Test plan
- Reset, then push 0x087 with `clock_disable`=0:
  - `gate_en` 0→1 at edge 1 and `fifo_rd_en` pulses at edge 2.
  - `alu_op`=0, `alu_a`=8, `alu_b`=7.
  - `res_valid`=1 at edge 5 and `issued_cnt`=1.
- Push 0x3A5 (div) with `DIV_LAT`=4: `alu_start` pulses once, `busy` stays high, and `res_valid` rises 4 cycles after `alu_start`.
- Push 8 instructions with `res_ready`=1:
  - 0x087, 0x1FC, 0x269, 0x3A5, 0x4B7, 0x54A, 0x62E, 0x760.
  - All 8 are popped in order, `issued_cnt`=8, and `fifo_rd_en` is never high while `fifo_empty`=1.
- Assert `clock_disable` during EXEC of a mul:
  - `gate_en` stays 1 through DONE.
  - After `res_ready`, → SLEEP with `gate_en`=0.
  - Deassert `clock_disable` with the FIFO non-empty → WAKE.
- Idle timeout: empty FIFO after DONE and `IDLE_CYCLES`=4 → `gate_en` falls exactly 4 cycles after entering IDLE.
- Push 0xF12: `illegal` pulses once, `issued_cnt` unchanged, no `alu_start`, no `res_valid`. Also hold `res_ready`=0 for 10 cycles on a legal op: `res_valid` stays 1 and no pop occurs.
